scm_wr_packer_32to64: RTL
=========================

Name: scm_wr_packer_32to64

Overview:
- Upstream write stage for the 64b-write / 32b-read latch SCM.
- Accepts a valid/ready stream of 32-bit words and packs consecutive pairs into one 64-bit row: first word into [31:0], second into [63:32].
- Issues one registered write per row, with an auto-incrementing row address starting at a programmable base.
- Word k of a burst is therefore readable at 32-bit read address 2*(base+row)+(k%2).

Parameters:
- WADDR_WIDTH, 5, row address width; row count is 2**WADDR_WIDTH.
- WDATA_WIDTH, 64, row width; fixed at 2*RDATA_WIDTH.
- RDATA_WIDTH, 32, input word width.
- PAD_VALUE, 32'h0000_0000, fill value for [63:32] of a row closed by a last word in the low half.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a burst; honoured only in IDLE.
- base_addr  in  WADDR_WIDTH  first row of the burst; sampled with start.
- in_valid  in  1  input word valid.
- in_ready  out  1  packer can accept a word.
- in_data  in  RDATA_WIDTH  input word.
- in_last  in  1  final word of the burst; qualified by in_valid.
- WriteEnable  out  1  row write strobe to the SCM; registered.
- WriteAddr  out  WADDR_WIDTH  row address; registered.
- WriteData  out  WDATA_WIDTH  packed row; registered.
- busy  out  1  high while in LO or HI.
- done  out  1  one-cycle pulse, the cycle after the final row write is issued.
- rows_written  out  WADDR_WIDTH+1  rows written in the current or most recent burst; saturates at 2**WADDR_WIDTH.
- overflow  out  1  sticky; set when a burst writes more than 2**WADDR_WIDTH rows; cleared by start.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, in_ready=0, WriteEnable=0, WriteAddr=0, WriteData=0, busy=0, done=0, rows_written=0, overflow=0, low-word holding register=0, address counter=0.
- Reset mid-burst discards any held low word; no write is issued for it.
- Handshake: a word is accepted in a cycle where in_valid && in_ready.
  - in_ready = (state==LO || state==HI); no combinational path from in_valid.
- FSM:
  - IDLE: in_ready=0. start -> load address counter with base_addr, clear rows_written and overflow, go to LO. No word is accepted in the start cycle.
  - LO: on accept, store in_data in the low register.
    - in_last=0 -> HI.
    - in_last=1 -> next cycle WriteEnable=1, WriteData={PAD_VALUE,in_data}, WriteAddr=counter; go to IDLE.
  - HI: on accept, next cycle WriteEnable=1, WriteData={in_data,low_reg}, WriteAddr=counter; counter++.
    - in_last=1 -> IDLE.
    - otherwise -> LO.
- Write latency: WriteEnable rises exactly 1 cycle after the accepting edge and lasts 1 cycle.
  - WriteAddr and WriteData change only when WriteEnable is asserted; otherwise they hold.
- done: asserted the cycle after the final WriteEnable (2 cycles after the last accept); 1 cycle wide.
- Counter wrap: address counter is WADDR_WIDTH bits and wraps from 2**WADDR_WIDTH-1 to 0.
  - rows_written increments per write and saturates.
  - overflow sets on the write that would take the unsaturated count past 2**WADDR_WIDTH.
- start outside IDLE is ignored. start in the same cycle as done is honoured, since state is already IDLE.
- in_valid while in IDLE is not accepted and not stored.
- Back-to-back: a full-rate stream (in_valid held high) gives one row write every 2 cycles with no bubbles.
- WADDR_WIDTH=0 (single row): counter absent, WriteAddr tied 0, every row writes row 0.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> all outputs 0. in_valid=1 in IDLE -> in_ready stays 0, no write.
- Burst of 4 words A0..A3, base_addr=3, in_valid held high -> two writes: addr 3 data {A1,A0}, addr 4 data {A3,A2}. Each WriteEnable is 1 cycle after its second-word accept. done is 1 cycle after the second write. rows_written=2.
- Odd burst of 3 words 0x11,0x22,0x33 with last on word 3, base 0 -> writes addr 0 {0x22,0x11} and addr 1 {PAD_VALUE,0x33}. State returns to IDLE.
- Wrap: WADDR_WIDTH=5, base 31, 4 words -> writes to addr 31 then 0. overflow=0.
- Overflow: base 0, 66 words -> 33 writes; addr 0 is written twice; rows_written=32; overflow=1. A following start clears overflow.
- Stalls and reset: random in_valid gaps -> packing and addresses unchanged. Assert rst_n low while in HI holding a low word -> no write occurs; after release state=IDLE and the next burst starts clean.

Source files
------------

// File: rtl/scm_wr_packer_32to64.sv
// -----------------------------------------------------------------------------
// scm_wr_packer_32to64
//
// Write-side packer for the 64b-write / 32b-read latch SCM.
// A valid/ready stream of 32-bit words is packed in pairs into 64-bit rows:
// the first word of a pair lands in [31:0] and the second in [63:32]. Each
// completed row is issued as one registered write. Row addresses
// auto-increment from a base sampled with start. Word k of a burst is
// therefore readable at 32-bit address 2*(base+row)+(k%2).
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         pulse; begins a burst (honoured only in IDLE)
//   base_addr     first row of the burst, sampled with start
//   in_valid      input word valid
//   in_ready      packer can accept a word (decoded from state only)
//   in_data       input word
//   in_last       final word of the burst, qualified by in_valid
//   WriteEnable   registered one-cycle row write strobe
//   WriteAddr     registered row address (holds between writes)
//   WriteData     registered packed row (holds between writes)
//   busy          high while in LO or HI
//   done          one-cycle pulse, the cycle after the final row write
//   rows_written  rows written in the current/most recent burst, saturating
//   overflow      sticky; burst wrote more rows than the SCM holds
//   state_dbg     current FSM state (0 IDLE, 1 LO, 2 HI)
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends on the state register only, never on in_valid; the
// producer may hold in_valid high for a full-rate stream, which yields one
// row write every two cycles with no bubbles.
// -----------------------------------------------------------------------------
module scm_wr_packer_32to64 #(
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int RDATA_WIDTH = 32,
  parameter logic [RDATA_WIDTH-1:0] PAD_VALUE = '0,
  // Physical width of the address signals; a zero-width address still needs
  // one wire, which is tied to 0.
  localparam int AW = (WADDR_WIDTH > 0) ? WADDR_WIDTH : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AW-1:0]          base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RDATA_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   WriteEnable,
  output logic [AW-1:0]          WriteAddr,
  output logic [WDATA_WIDTH-1:0] WriteData,
  output logic                   busy,
  output logic                   done,
  output logic [WADDR_WIDTH:0]   rows_written,
  output logic                   overflow,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // Row count of the SCM; rows_written saturates here.
  localparam logic [WADDR_WIDTH:0] ROW_MAX = (WADDR_WIDTH + 1)'(2 ** WADDR_WIDTH);

  state_t                 state;
  logic [RDATA_WIDTH-1:0] low_q;      // first word of the pair being built
  logic [AW-1:0]          addr_cnt;   // row address of the next write
  logic                   last_wr_q;  // the write now on the bus closes the burst

  logic                   accept;
  logic [AW-1:0]          addr_inc;
  logic [AW-1:0]          addr_load;
  logic [WADDR_WIDTH:0]   rows_next;
  logic                   ovf_hit;

  assign accept = in_valid && in_ready;

  // With a single row there is no counter: every write goes to row 0.
  assign addr_inc  = (WADDR_WIDTH > 0) ? AW'(addr_cnt + 1'b1) : '0;
  assign addr_load = (WADDR_WIDTH > 0) ? base_addr : '0;

  // Row accounting applied on every write issue. Once the count has reached
  // the row total, a further write means the burst has overwritten a row.
  always_comb begin
    rows_next = rows_written;
    ovf_hit   = 1'b0;
    if (rows_written == ROW_MAX) begin
      ovf_hit = 1'b1;
    end else begin
      rows_next = rows_written + 1'b1;
    end
  end

  assign in_ready  = (state == LO) || (state == HI);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      low_q        <= '0;
      addr_cnt     <= '0;
      last_wr_q    <= 1'b0;
      WriteEnable  <= 1'b0;
      WriteAddr    <= '0;
      WriteData    <= '0;
      done         <= 1'b0;
      rows_written <= '0;
      overflow     <= 1'b0;
    end else begin
      // Strobes default low; address and data hold between writes.
      WriteEnable <= 1'b0;
      last_wr_q   <= 1'b0;
      done        <= last_wr_q;

      case (state)
        IDLE: begin
          if (start) begin
            addr_cnt     <= addr_load;
            rows_written <= '0;
            overflow     <= 1'b0;
            state        <= LO;
          end
        end

        LO: begin
          if (accept) begin
            low_q <= in_data;
            if (in_last) begin
              // Odd burst: close the row with the pad in the upper half.
              WriteEnable  <= 1'b1;
              WriteAddr    <= addr_cnt;
              WriteData    <= {PAD_VALUE, in_data};
              rows_written <= rows_next;
              if (ovf_hit) overflow <= 1'b1;
              last_wr_q    <= 1'b1;
              state        <= IDLE;
            end else begin
              state <= HI;
            end
          end
        end

        HI: begin
          if (accept) begin
            WriteEnable  <= 1'b1;
            WriteAddr    <= addr_cnt;
            WriteData    <= {in_data, low_q};
            addr_cnt     <= addr_inc;
            rows_written <= rows_next;
            if (ovf_hit) overflow <= 1'b1;
            if (in_last) begin
              last_wr_q <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= LO;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
